// File: rtl/multiciclo_control_pkg.sv
// Shared definitions for the RV32I multicycle main control FSM.
// Holds the opcode constants, the FSM state encoding and the
// datapath mux-select encodings used by the control outputs.
package multiciclo_control_pkg;

    // RV32I base opcodes (IR[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // FSM states; 14 used codes out of 16
    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StLui      = 4'd8,
        StAluWb    = 4'd9,
        StBranch   = 4'd10,
        StJal      = 4'd11,
        StJalr     = 4'd12,
        StIllegal  = 4'd13
    } stateT;

    // ALU A input select
    localparam logic [1:0] ASRC_PC    = 2'b00;
    localparam logic [1:0] ASRC_REGA  = 2'b01;
    localparam logic [1:0] ASRC_PCOLD = 2'b10;
    localparam logic [1:0] ASRC_ZERO  = 2'b11;

    // ALU B input select
    localparam logic [1:0] BSRC_REGB  = 2'b00;
    localparam logic [1:0] BSRC_FOUR  = 2'b01;
    localparam logic [1:0] BSRC_IMM   = 2'b10;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    // Register-file write data select
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    // ALU operation class, refined by alu_control
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

endpackage

// File: rtl/multiciclo_control_counter.sv
// Retired-instruction counter for the multicycle control FSM.
// Ports:
//   clock   - system clock, rising edge
//   reset_n - asynchronous active-low reset, clears the count
//   retire  - one retirement this cycle; count advances on the edge
//   count   - current count, wraps modulo 2^CNT_W
module multiciclo_control_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             retire,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] countQ;
    logic [CNT_W-1:0] countD;

    always_comb begin
        countD = countQ;
        if (retire) begin
            countD = countQ + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            countQ <= '0;
        end else begin
            countQ <= countD;
        end
    end

    assign count = countQ;

endmodule

// File: rtl/multiciclo_control.sv
// Main control FSM for the RV32I multicycle datapath.
// Decodes the IR opcode and drives the memory, register-file, PC and
// ALU/mux controls each cycle; memory states stall on MemReady.
// Ports:
//   clock, reset_n          - clock and asynchronous active-low reset
//   Opcode                  - IR[6:0]
//   MemReady                - memory completes current access this cycle
//   ReadMemory, WriteMemory - memory enables; IorD selects address (0=PC)
//   IRWrite                 - latch ReadData into IR and PC into PCOld
//   PCWrite, PCWriteCond    - unconditional / branch-taken PC update
//   PCSource, MemtoReg      - next-PC and rd write-data selects
//   RegWrite                - register file write enable
//   ALUSrcA, ALUSrcB, ALUOp - ALU operand and operation selects
//   Illegal                 - unsupported opcode seen (held until reset)
//   Instret                 - retired-instruction count
module multiciclo_control
    import multiciclo_control_pkg::*;
#(
    parameter bit          WAIT_MEM = 1'b1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [6:0]       Opcode,
    input  logic             MemReady,
    output logic             ReadMemory,
    output logic             WriteMemory,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic [1:0]       PCSource,
    output logic             RegWrite,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             Illegal,
    output logic [CNT_W-1:0] Instret
);

    stateT stateQ;
    stateT stateD;
    logic  memReady;
    logic  retire;

    // With WAIT_MEM=0 every memory access is treated as single-cycle
    assign memReady = WAIT_MEM ? MemReady : 1'b1;

    always_comb begin
        stateD      = stateQ;
        retire      = 1'b0;
        ReadMemory  = 1'b0;
        WriteMemory = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = PCSRC_ALU;
        RegWrite    = 1'b0;
        MemtoReg    = M2R_ALUOUT;
        ALUSrcA     = ASRC_PC;
        ALUSrcB     = BSRC_REGB;
        ALUOp       = ALUOP_ADD;
        Illegal     = 1'b0;

        unique case (stateQ)
            StFetch: begin
                // PC+4 computed in parallel with the instruction read
                ReadMemory = 1'b1;
                ALUSrcB    = BSRC_FOUR;
                IRWrite    = memReady;
                PCWrite    = memReady;
                if (memReady) begin
                    stateD = StDecode;
                end
            end
            StDecode: begin
                // Speculative branch/JAL target: ALUOut = PCOld + Imm
                ALUSrcA = ASRC_PCOLD;
                ALUSrcB = BSRC_IMM;
                case (Opcode)
                    OPC_LOAD, OPC_STORE: stateD = StMemAddr;
                    OPC_OP:              stateD = StExecR;
                    OPC_OPIMM:           stateD = StExecI;
                    OPC_BRANCH:          stateD = StBranch;
                    OPC_JAL:             stateD = StJal;
                    OPC_JALR:            stateD = StJalr;
                    OPC_LUI:             stateD = StLui;
                    OPC_AUIPC:           stateD = StAluWb;
                    default:             stateD = StIllegal;
                endcase
            end
            StMemAddr: begin
                ALUSrcA = ASRC_REGA;
                ALUSrcB = BSRC_IMM;
                stateD  = (Opcode == OPC_LOAD) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                ReadMemory = 1'b1;
                IorD       = 1'b1;
                if (memReady) begin
                    stateD = StMemWb;
                end
            end
            StMemWb: begin
                RegWrite = 1'b1;
                MemtoReg = M2R_MDR;
                retire   = 1'b1;
                stateD   = StFetch;
            end
            StMemWrite: begin
                WriteMemory = 1'b1;
                IorD        = 1'b1;
                if (memReady) begin
                    retire = 1'b1;
                    stateD = StFetch;
                end
            end
            StExecR: begin
                ALUSrcA = ASRC_REGA;
                ALUSrcB = BSRC_REGB;
                ALUOp   = ALUOP_FUNCT;
                stateD  = StAluWb;
            end
            StExecI: begin
                ALUSrcA = ASRC_REGA;
                ALUSrcB = BSRC_IMM;
                ALUOp   = ALUOP_FUNCT;
                stateD  = StAluWb;
            end
            StLui: begin
                ALUSrcA = ASRC_ZERO;
                ALUSrcB = BSRC_IMM;
                stateD  = StAluWb;
            end
            StAluWb: begin
                RegWrite = 1'b1;
                MemtoReg = M2R_ALUOUT;
                retire   = 1'b1;
                stateD   = StFetch;
            end
            StBranch: begin
                ALUSrcA     = ASRC_REGA;
                ALUSrcB     = BSRC_REGB;
                ALUOp       = ALUOP_BRANCH;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                retire      = 1'b1;
                stateD      = StFetch;
            end
            StJal: begin
                // rd gets the current PC, which already holds PCOld+4
                PCWrite  = 1'b1;
                PCSource = PCSRC_ALUOUT;
                RegWrite = 1'b1;
                MemtoReg = M2R_PC;
                retire   = 1'b1;
                stateD   = StFetch;
            end
            StJalr: begin
                ALUSrcA  = ASRC_REGA;
                ALUSrcB  = BSRC_IMM;
                PCWrite  = 1'b1;
                PCSource = PCSRC_JALR;
                RegWrite = 1'b1;
                MemtoReg = M2R_PC;
                retire   = 1'b1;
                stateD   = StFetch;
            end
            StIllegal: begin
                // Absorbing: only reset_n leaves this state
                Illegal = 1'b1;
            end
            default: begin
                stateD = StFetch;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateQ <= StFetch;
        end else begin
            stateQ <= stateD;
        end
    end

    multiciclo_control_counter #(
        .CNT_W (CNT_W)
    ) uCounter (
        .clock   (clock),
        .reset_n (reset_n),
        .retire  (retire),
        .count   (Instret)
    );

endmodule

// File: doc/multiciclo_control.md
Name: multiciclo_control

Overview:
- Main control FSM for the RV32I multicycle datapath.
- Sits directly upstream of the datapath and the unified Memory instance:
  - decodes the opcode held in the instruction register;
  - drives ReadMemory/WriteMemory, IorD, IRWrite, PCWrite, RegWrite and the ALU/mux selects each cycle;
  - stalls on the memory ready handshake.
- Also provides a retired-instruction counter and a sticky illegal-opcode flag.

Parameters:
- WAIT_MEM, 1, when 1 memory states hold until MemReady=1; when 0 MemReady is ignored and treated as 1.
- CNT_W, 32, width of the Instret counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- Opcode  in  7  IR[6:0] of the current instruction.
- MemReady  in  1  memory completes the current read/write this cycle.
- ReadMemory  out  1  memory read enable.
- WriteMemory  out  1  memory write enable.
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- IRWrite  out  1  latch ReadData into IR and latch PC into PCOld.
- PCWrite  out  1  unconditional PC update.
- PCWriteCond  out  1  PC update if the ALU branch-taken flag is set.
- PCSource  out  2  next-PC select: 00=ALU result, 01=ALUOut, 10=ALU result with bit0 cleared.
- RegWrite  out  1  register file write enable.
- MemtoReg  out  2  rd write data: 00=ALUOut, 01=MDR, 10=PC.
- ALUSrcA  out  2  ALU A input: 00=PC, 01=A register, 10=PCOld, 11=zero.
- ALUSrcB  out  2  ALU B input: 00=B register, 01=constant 4, 10=Imm.
- ALUOp  out  2  ALU operation: 00=add, 01=branch compare (funct3), 10=decode funct3/funct7.
- Illegal  out  1  sticky flag: unsupported opcode seen.
- Instret  out  CNT_W  count of retired instructions.

Behaviour:
- Reset: asynchronous; on assertion state=FETCH, Instret=0, Illegal=0.
  - Outputs are Moore-decoded from state (plus MemReady in FETCH), so during reset they show FETCH values.
- All outputs not listed for a state are 0. State register is 4 bits, 14 states.
- FETCH:
  - ReadMemory=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=MemReady.
  - Holds while MemReady=0; otherwise goes to DECODE.
- DECODE: ALUSrcA=10, ALUSrcB=10, ALUOp=00 (ALUOut=PCOld+Imm). Next state by Opcode:
  - 0000011 or 0100011 -> MEMADDR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> ALUWB (AUIPC)
  - any other -> ILLEGAL
- MEMADDR: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Next is MEMREAD if Opcode=0000011, else MEMWRITE.
- MEMREAD: ReadMemory=1, IorD=1. Holds until MemReady, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=01. Retires; next FETCH.
- MEMWRITE: WriteMemory=1, IorD=1. Holds until MemReady, then retires; next FETCH.
- EXEC_R: ALUSrcA=01, ALUSrcB=00, ALUOp=10. Next ALUWB.
- EXEC_I: ALUSrcA=01, ALUSrcB=10, ALUOp=10. Next ALUWB.
- LUI: ALUSrcA=11, ALUSrcB=10, ALUOp=00. Next ALUWB.
- ALUWB: RegWrite=1, MemtoReg=00. Retires; next FETCH.
- BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Retires; next FETCH.
- JAL: PCWrite=1, PCSource=01, RegWrite=1, MemtoReg=10. Retires; next FETCH.
  - rd receives the pre-edge PC (already PCOld+4).
- JALR: ALUSrcA=01, ALUSrcB=10, ALUOp=00, PCWrite=1, PCSource=10, RegWrite=1, MemtoReg=10. Retires; next FETCH.
- ILLEGAL: Illegal=1, all enables 0. Absorbing until reset_n low.
- Instret increments by 1 on the edge leaving a retiring state. Wraps modulo 2^CNT_W.
- Throughput in cycles per instruction, with MemReady always 1:
  - load 5
  - store 4
  - R/I/LUI/AUIPC 4 (AUIPC 3)
  - branch 3
  - JAL/JALR 3
- Each cycle of MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- MemReady is only sampled in FETCH, MEMREAD and MEMWRITE; it is ignored elsewhere.
- reset_n low mid-instruction: immediately FETCH. Partial writes already committed are not undone.
- WAIT_MEM=0 makes every memory state single-cycle regardless of MemReady.

Decomposition:
- Shared package/params include holds:
  - opcode constants (OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC);
  - state encodings;
  - mux-select encodings for ALUSrcA/B, PCSource, MemtoReg, ALUOp.
- The ALU-side funct decoder is a separate sub-module, alu_control (ALUOp + funct3/funct7 -> ALU function). It is not part of this block.

Test Plan:
- Reset, MemReady=1, Opcode=0110011 -> state sequence FETCH, DECODE, EXEC_R, ALUWB, FETCH; RegWrite=1 only in cycle 4; Instret=1 after cycle 4.
- Load with MemReady held 0 for 3 cycles in MEMREAD -> ReadMemory=1, IorD=1 for 4 cycles; MEMWB follows; total 8 cycles; Instret+1.
- Store, MemReady=1 -> WriteMemory=1 exactly one cycle, in cycle 4; RegWrite never 1.
- Opcode=1101111 -> JAL in cycle 3 with PCWrite=1, PCSource=01, MemtoReg=10; returns to FETCH in cycle 4.
- Opcode=1111111 -> ILLEGAL from cycle 3; Illegal=1; all enables 0 for 20 cycles; Instret unchanged; reset_n pulse clears Illegal and restarts FETCH.
- reset_n asserted asynchronously mid-MEMWRITE -> WriteMemory drops before the next edge; state=FETCH; Instret=0.
